// File: rtl/itcm_boot_loader_if.sv
// Flash read port and ITCM write port of the ITCM boot loader.
interface itcm_boot_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Flash: flash_req rises with a word-aligned flash_addr. Both stay stable
  // until flash_ready=1, the cycle in which flash_rdata is valid and the read
  // completes. ITCM: itcm_wr is a one-cycle write strobe with no back-pressure.
  logic                  flash_req;
  logic [ADDR_WIDTH-1:0] flash_addr;
  logic                  flash_ready;
  logic [DATA_WIDTH-1:0] flash_rdata;
  logic                  itcm_wr;
  logic [ADDR_WIDTH-1:0] itcm_addr;
  logic [DATA_WIDTH-1:0] itcm_wdata;
  logic [3:0]            itcm_byte_strobe;

  modport master (
    output flash_req, flash_addr,
    input  flash_ready, flash_rdata,
    output itcm_wr, itcm_addr, itcm_wdata, itcm_byte_strobe
  );

  modport slave (
    input  flash_req, flash_addr,
    output flash_ready, flash_rdata,
    input  itcm_wr, itcm_addr, itcm_wdata, itcm_byte_strobe
  );
endinterface

// File: rtl/itcm_boot_loader.sv
// Boot-time flash-to-ITCM copy engine; holds the core in reset until done.
// KRV_ITCM_LOAD_CHECKSUM_EN adds a trailing checksum word check (CHK/ERR).
module itcm_boot_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] FLASH_BASE = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] ITCM_BASE  = 32'h0001_0000,
  parameter int                    LOAD_WORDS = 1024
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                auto_load_en,
  itcm_boot_loader_if.master  bus,
  output logic                itcm_auto_load,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_err,
  output logic [2:0]          dbg_state
);

  localparam int CW = $clog2(LOAD_WORDS) + 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(LOAD_WORDS - 1);
  localparam logic [CW-1:0] CHK_INDEX = CW'(LOAD_WORDS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
`ifdef KRV_ITCM_LOAD_CHECKSUM_EN
    S_CHK  = 3'd3,
    S_ERR  = 3'd5,
`endif
    S_DONE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  flash_req_q, flash_req_d;
  logic [ADDR_WIDTH-1:0] flash_addr_q, flash_addr_d;
  logic                  itcm_wr_q, itcm_wr_d;
  logic [ADDR_WIDTH-1:0] itcm_addr_q, itcm_addr_d;
  logic [DATA_WIDTH-1:0] itcm_wdata_q, itcm_wdata_d;
  logic [3:0]            strb_q, strb_d;
  logic                  auto_q, auto_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
`ifdef KRV_ITCM_LOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  err_q, err_d;
`endif

  function automatic logic [ADDR_WIDTH-1:0] word_off(input logic [CW-1:0] idx);
    return ADDR_WIDTH'(idx) << 2;
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flash_req_d  = flash_req_q;
    flash_addr_d = flash_addr_q;
    itcm_wr_d    = 1'b0;
    itcm_addr_d  = itcm_addr_q;
    itcm_wdata_d = itcm_wdata_q;
    strb_d       = 4'h0;
    auto_d       = auto_q;
    hold_d       = hold_q;
    done_d       = done_q;
`ifdef KRV_ITCM_LOAD_CHECKSUM_EN
    sum_d        = sum_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (auto_load_en) begin
          state_d      = S_RD;
          auto_d       = 1'b1;
          flash_req_d  = 1'b1;
          flash_addr_d = FLASH_BASE;
        end else begin
          state_d = S_DONE;
          hold_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_RD: begin
        if (bus.flash_ready) begin
          state_d      = S_WR;
          flash_req_d  = 1'b0;
          itcm_wdata_d = bus.flash_rdata;
          itcm_wr_d    = 1'b1;
          strb_d       = 4'hF;
          itcm_addr_d  = ITCM_BASE + word_off(cnt_q);
`ifdef KRV_ITCM_LOAD_CHECKSUM_EN
          sum_d        = sum_q + bus.flash_rdata;
`endif
        end
      end
      S_WR: begin
        if (cnt_q == LAST_CNT) begin
`ifdef KRV_ITCM_LOAD_CHECKSUM_EN
          // The stored checksum sits in the flash word right after the image.
          state_d      = S_CHK;
          flash_req_d  = 1'b1;
          flash_addr_d = FLASH_BASE + word_off(CHK_INDEX);
`else
          state_d = S_DONE;
          auto_d  = 1'b0;
          hold_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end else begin
          state_d      = S_RD;
          cnt_d        = cnt_q + 1'b1;
          flash_req_d  = 1'b1;
          flash_addr_d = FLASH_BASE + word_off(cnt_q + 1'b1);
        end
      end
`ifdef KRV_ITCM_LOAD_CHECKSUM_EN
      S_CHK: begin
        if (bus.flash_ready) begin
          flash_req_d = 1'b0;
          auto_d      = 1'b0;
          if (bus.flash_rdata == sum_q) begin
            state_d = S_DONE;
            hold_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_ERR: begin
        auto_d = 1'b0;
        err_d  = 1'b1;
      end
`endif
      S_DONE: begin
        auto_d = 1'b0;
        hold_d = 1'b0;
        done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      flash_req_q  <= 1'b0;
      flash_addr_q <= FLASH_BASE;
      itcm_wr_q    <= 1'b0;
      itcm_addr_q  <= ITCM_BASE;
      itcm_wdata_q <= '0;
      strb_q       <= 4'h0;
      auto_q       <= 1'b0;
      hold_q       <= 1'b1;
      done_q       <= 1'b0;
`ifdef KRV_ITCM_LOAD_CHECKSUM_EN
      sum_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flash_req_q  <= flash_req_d;
      flash_addr_q <= flash_addr_d;
      itcm_wr_q    <= itcm_wr_d;
      itcm_addr_q  <= itcm_addr_d;
      itcm_wdata_q <= itcm_wdata_d;
      strb_q       <= strb_d;
      auto_q       <= auto_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
`ifdef KRV_ITCM_LOAD_CHECKSUM_EN
      sum_q        <= sum_d;
      err_q        <= err_d;
`endif
    end
  end

  assign bus.flash_req        = flash_req_q;
  assign bus.flash_addr       = flash_addr_q;
  assign bus.itcm_wr          = itcm_wr_q;
  assign bus.itcm_addr        = itcm_addr_q;
  assign bus.itcm_wdata       = itcm_wdata_q;
  assign bus.itcm_byte_strobe = strb_q;
  assign itcm_auto_load       = auto_q;
  assign cpu_hold             = hold_q;
  assign load_done            = done_q;
  assign dbg_state            = state_q;
`ifdef KRV_ITCM_LOAD_CHECKSUM_EN
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_itcm_boot_loader.sv
// Directed bench for itcm_boot_loader with a 4-word image and a flash model
// with configurable wait states; ITCM writes are scored against exp_q.
module tb_itcm_boot_loader;

  localparam logic [31:0] FB = 32'h0000_0100;
  localparam logic [31:0] IB = 32'h0001_0000;
  localparam int          NW = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  logic       HCLK;
  logic       HRESETn;
  logic       auto_load_en;
  logic       itcm_auto_load;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;
  logic [2:0] dbg_state;

  itcm_boot_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  itcm_boot_loader #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .FLASH_BASE(FB), .ITCM_BASE(IB), .LOAD_WORDS(NW)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .auto_load_en(auto_load_en),
    .bus(bus.master),
    .itcm_auto_load(itcm_auto_load),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .load_err(load_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // flash image, model state and scoreboard
  logic [31:0] mem [0:NW];
  logic [63:0] exp_q [$];
  int          max_wait;
  int          wait_left;
  bit          inject;
  bit          arm_wr;
  bit          arm_done;
  int          wr_count;
  int          req_seen;
  int          unstable;
  bit          hold_valid;
  logic [31:0] held_addr;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push_image();
    exp_q.delete();
    for (int i = 0; i < NW; i++) exp_q.push_back({IB + 32'(4 * i), mem[i]});
  endtask

  // One cycle: sample at the falling edge, then set flash inputs for the next rise.
  task automatic tick();
    int idx;
    @(negedge HCLK);
    if (bus.flash_req) req_seen++;
    if (bus.itcm_wr === 1'b1) begin
      wr_count++;
      check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("wr_addr_data", {bus.itcm_addr, bus.itcm_wdata}, exp_q.pop_front());
      check("wr_strobe", 64'(bus.itcm_byte_strobe), 64'hF);
    end
    if (bus.flash_req && !bus.flash_ready) begin
      if (hold_valid && bus.flash_addr !== held_addr) unstable++;
      held_addr  = bus.flash_addr;
      hold_valid = 1'b1;
    end else begin
      hold_valid = 1'b0;
    end
    if (arm_wr && dbg_state == ST_WR) begin inject = 1'b1; arm_wr = 1'b0; end
    if (arm_done && dbg_state == ST_DONE) begin inject = 1'b1; arm_done = 1'b0; end
    if (inject) begin
      bus.flash_ready = 1'b1;
      bus.flash_rdata = 32'hDEAD_BEEF;
      inject = 1'b0;
    end else if (bus.flash_ready) begin
      bus.flash_ready = 1'b0;
      wait_left = int'($urandom_range(max_wait, 0));
    end else if (bus.flash_req) begin
      if (wait_left == 0) begin
        idx = int'((bus.flash_addr - FB) >> 2);
        bus.flash_ready = 1'b1;
        bus.flash_rdata = (idx >= 0 && idx <= NW) ? mem[idx] : 32'hBAD0_BAD0;
      end else begin
        wait_left--;
      end
    end
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    bus.flash_ready = 1'b0;
    inject = 1'b0;
    tick();
    tick();
    wr_count = 0;
    req_seen = 0;
    unstable = 0;
    hold_valid = 1'b0;
    wait_left = 0;
    HRESETn = 1'b1;
  endtask

  task automatic run_to_end(input string tag, input int budget);
    int k;
    k = 0;
    while (!(load_done || load_err) && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(load_done || load_err), 64'd1);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_flash_req"},  64'(bus.flash_req), 64'd0);
    check({pfx, "_flash_addr"}, 64'(bus.flash_addr), 64'(FB));
    check({pfx, "_itcm_wr"},    64'(bus.itcm_wr), 64'd0);
    check({pfx, "_itcm_addr"},  64'(bus.itcm_addr), 64'(IB));
    check({pfx, "_itcm_wdata"}, 64'(bus.itcm_wdata), 64'd0);
    check({pfx, "_strobe"},     64'(bus.itcm_byte_strobe), 64'd0);
    check({pfx, "_auto_load"},  64'(itcm_auto_load), 64'd0);
    check({pfx, "_cpu_hold"},   64'(cpu_hold), 64'd1);
    check({pfx, "_load_done"},  64'(load_done), 64'd0);
    check({pfx, "_load_err"},   64'(load_err), 64'd0);
    check({pfx, "_state"},      64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    int auto_cnt;
    int done_tick;
    n_checks = 0;
    n_pass = 0;
    max_wait = 0;
    wait_left = 0;
    inject = 1'b0;
    arm_wr = 1'b0;
    arm_done = 1'b0;
    hold_valid = 1'b0;
    held_addr = '0;
    wr_count = 0;
    req_seen = 0;
    unstable = 0;
    auto_load_en = 1'b0;
    bus.flash_ready = 1'b0;
    bus.flash_rdata = '0;
    HRESETn = 1'b1;
    #2 HRESETn = 1'b0;

    // Reset values
    tick();
    tick();
    check_reset_values("rst");

    // Strap low: straight to DONE, no traffic
    auto_load_en = 1'b0;
    exp_q.delete();
    do_reset();
    check("nolo_hold_at_release", 64'(cpu_hold), 64'd1);
    tick();
    tick();
    check("nolo_cpu_hold", 64'(cpu_hold), 64'd0);
    check("nolo_load_done", 64'(load_done), 64'd1);
    for (int i = 0; i < 8; i++) tick();
    check("nolo_req_seen", 64'(req_seen), 64'd0);
    check("nolo_wr_count", 64'(wr_count), 64'd0);
    check("nolo_state", 64'(dbg_state), 64'(ST_DONE));
    check("nolo_auto_load", 64'(itcm_auto_load), 64'd0);

    // Zero-wait copy of 0x11..0x44, ready pulsed in DONE
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44; mem[4] = 32'hAA;
    max_wait = 0;
    auto_load_en = 1'b1;
    push_image();
    do_reset();
    auto_cnt = 0;
    done_tick = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 3) auto_load_en = 1'b0;
      if (itcm_auto_load) auto_cnt++;
      if (load_done && done_tick == 0) done_tick = k;
      if (k == 12) arm_done = 1'b1;
    end
`ifdef KRV_ITCM_LOAD_CHECKSUM_EN
    check("zw_auto_cycles", 64'(auto_cnt), 64'd9);
    check("zw_done_cycle", 64'(done_tick), 64'd10);
`else
    check("zw_auto_cycles", 64'(auto_cnt), 64'd8);
    check("zw_done_cycle", 64'(done_tick), 64'd9);
`endif
    check("zw_missing_wr", 64'(exp_q.size()), 64'd0);
    check("zw_wr_count", 64'(wr_count), 64'd4);
    check("zw_state_after_pulse", 64'(dbg_state), 64'(ST_DONE));
    check("zw_cpu_hold", 64'(cpu_hold), 64'd0);
    check("zw_load_err", 64'(load_err), 64'd0);
    check("zw_arm_done_used", 64'(arm_done), 64'd0);

    // Random 0-5 wait states, stray ready pulse during WR
    mem[0] = 32'h1234_5678; mem[1] = 32'h9ABC_DEF0; mem[2] = 32'h0F0F_0F0F;
    mem[3] = 32'hF0F0_F0F0; mem[4] = 32'hACF1_3567;
    max_wait = 5;
    auto_load_en = 1'b1;
    push_image();
    do_reset();
    wait_left = int'($urandom_range(5, 0));
    arm_wr = 1'b1;
    run_to_end("rw_finished", 400);
    check("rw_load_done", 64'(load_done), 64'd1);
    check("rw_missing_wr", 64'(exp_q.size()), 64'd0);
    check("rw_wr_count", 64'(wr_count), 64'd4);
    check("rw_addr_stable", 64'(unstable), 64'd0);
    check("rw_arm_wr_used", 64'(arm_wr), 64'd0);

    // Reset while reading word 2, then a full restart
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44; mem[4] = 32'hAA;
    max_wait = 0;
    push_image();
    do_reset();
    for (int k = 0; k < 50 && wr_count < 2; k++) tick();
    tick();
    check("mid_state_rd", 64'(dbg_state), 64'(ST_RD));
    check("mid_flash_addr", 64'(bus.flash_addr), 64'(FB + 32'h8));
    HRESETn = 1'b0;
    bus.flash_ready = 1'b0;
    #1;
    check_reset_values("mid");
    push_image();
    do_reset();
    tick();
    check("restart_req", 64'(bus.flash_req), 64'd1);
    check("restart_addr", 64'(bus.flash_addr), 64'(FB));
    run_to_end("restart_finished", 100);
    check("restart_missing_wr", 64'(exp_q.size()), 64'd0);
    check("restart_wr_count", 64'(wr_count), 64'd4);

`ifdef KRV_ITCM_LOAD_CHECKSUM_EN
    // Checksum good (1+2+3+4 = 0xA) then bad (0xB)
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4; mem[4] = 32'hA;
    push_image();
    do_reset();
    run_to_end("ck_good_finished", 100);
    check("ck_good_done", 64'(load_done), 64'd1);
    check("ck_good_err", 64'(load_err), 64'd0);
    check("ck_good_hold", 64'(cpu_hold), 64'd0);
    mem[4] = 32'hB;
    push_image();
    do_reset();
    run_to_end("ck_bad_finished", 100);
    for (int i = 0; i < 3; i++) tick();
    check("ck_bad_err", 64'(load_err), 64'd1);
    check("ck_bad_done", 64'(load_done), 64'd0);
    check("ck_bad_hold", 64'(cpu_hold), 64'd1);
    check("ck_bad_auto_load", 64'(itcm_auto_load), 64'd0);
    check("ck_bad_state", 64'(dbg_state), 64'(ST_ERR));
    check("ck_bad_wr_count", 64'(wr_count), 64'd4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
